adc_spi_scheduler: RTL and testbench
====================================

Name: adc_spi_scheduler

Overview:
- Round-robin arbiter and sequencer that shares the single 8-channel, 12-bit ADC SPI engine between NREQ requesters, such as scope capture channels and the seven-segment monitor.
- Each requester asks for one conversion on a 3-bit ADC channel address.
- The scheduler grants one requester, drives the engine's channel address and start strobe, waits for completion, then returns the 12-bit result tagged to the winning requester.
- Sits between the capture/display logic and the SPI engine (clk, sclk, din, cs, ADD, 12-bit result).

Parameters:
- NREQ, 3, number of requesters (2..8).
- CH_W, 3, ADC channel address width.
- DATA_W, 12, conversion result width.
- TIMEOUT_CYC, 4096, clk cycles allowed in WAIT before abort (used only with ADC_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester conversion request (level, held until gnt).
- req_ch  in  NREQ*CH_W  channel address per requester; requester i uses bits [i*CH_W +: CH_W].
- gnt  out  NREQ  one-hot, one-cycle grant pulse.
- rsp_valid  out  NREQ  one-hot, one-cycle result-valid pulse to the winner.
- rsp_data  out  DATA_W  result; held until the next rsp_valid.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- spi_add  out  CH_W  channel address to the SPI engine; held from grant until the next grant.
- spi_start  out  1  one-cycle conversion start pulse.
- spi_busy  in  1  SPI engine frame in progress.
- spi_done  in  1  one-cycle pulse; spi_data is valid in the same cycle.
- spi_data  in  DATA_W  conversion result from the SPI engine.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; gnt, rsp_valid, spi_start, rsp_err = 0; rsp_data=0; spi_add=0; ptr=NREQ-1, so requester 0 has first priority.
- States:
  - IDLE -> ARB_GNT when |req.
  - ARB_GNT -> START.
  - START -> WAIT.
  - WAIT -> RESP on spi_done.
  - RESP -> IDLE.
- IDLE, cycle N: req sampled. Winner = first set bit searching ptr+1, ptr+2, ... modulo NREQ. Winner index and its req_ch are latched.
- ARB_GNT, cycle N+1: gnt[winner]=1 and spi_add=latched channel, both registered. ptr<=winner. Requester may drop req from N+2.
- START: if spi_busy=1, stay with spi_start=0. Else spi_start=1 for exactly one cycle (earliest N+2), then WAIT.
- WAIT: spi_done is sampled. At done cycle M, spi_data is captured.
- RESP, cycle M+1: rsp_valid[winner]=1, rsp_data=captured value, rsp_err=0. Next cycle IDLE, so the next gnt comes no earlier than M+3.
- Boundary and corner cases:
  - req deasserted before its gnt: ignored, no grant.
  - req changes while not in IDLE: no effect on the current transaction.
  - spi_done outside WAIT: ignored.
  - spi_done in the same cycle as spi_start: ignored, since WAIT has not been entered.
  - Requester re-asserting req immediately after its rsp_valid: loses to other pending requesters (fairness). With no others pending it is re-granted.
  - req_ch change after grant: does not alter spi_add.
  - Reset during WAIT: transaction abandoned, no rsp_valid, spi_start stays 0. The SPI engine frame completes on its own and its spi_done is ignored.
- At most one transaction is outstanding. gnt and rsp_valid are never asserted simultaneously.

Optional Feature:
- Macro ADC_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - Reaching TIMEOUT_CYC-1 without spi_done: RESP with rsp_valid[winner]=1, rsp_err=1, rsp_data=0.
  - spi_done in that same cycle takes precedence (normal response, rsp_err=0).
- Undefined: no counter; WAIT lasts indefinitely; rsp_err tied 0.

Test Plan:
- Single request: req=3'b001, req_ch[2:0]=5, spi_done with spi_data=12'hAC5 four cycles after spi_start -> gnt=001 one cycle, spi_add=5, one spi_start pulse, rsp_valid=001 and rsp_data=12'hAC5 one cycle after done.
- Simultaneous requests: req=3'b111 held with re-request after each response -> grant order 0,1,2,0,1,2; each rsp_valid bit matches the preceding gnt bit.
- Requests 0 and 2 pending after requester 1 served -> requester 2 granted before 0.
- spi_busy high for 10 cycles in START -> spi_start withheld, then a single pulse the cycle after busy falls.
- Reset pulse mid-WAIT, then a late spi_done -> all outputs 0 and no rsp_valid. The next req=3'b010 is granted requester 1.
- ADC_TIMEOUT_EN with TIMEOUT_CYC=16 and no spi_done -> rsp_valid plus rsp_err=1 and rsp_data=0 exactly 16 cycles after entering WAIT. Without the macro, state remains WAIT.

Source files
------------

// File: rtl/adc_spi_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_scheduler_if
// Brief    : Requester/SPI-engine bundle for the shared ADC scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface adc_spi_scheduler_if #(
    parameter int NREQ   = 3,
    parameter int CH_W   = 3,
    parameter int DATA_W = 12
);
    logic [NREQ-1:0]      req;
    logic [NREQ*CH_W-1:0] req_ch;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rsp_valid;
    logic [DATA_W-1:0]    rsp_data;
    logic                 rsp_err;
    logic [CH_W-1:0]      spi_add;
    logic                 spi_start;
    logic                 spi_busy;
    logic                 spi_done;
    logic [DATA_W-1:0]    spi_data;

    modport slave (
        input  req, req_ch, spi_busy, spi_done, spi_data,
        output gnt, rsp_valid, rsp_data, rsp_err, spi_add, spi_start
    );

    modport master (
        output req, req_ch, spi_busy, spi_done, spi_data,
        input  gnt, rsp_valid, rsp_data, rsp_err, spi_add, spi_start
    );
endinterface
`default_nettype wire

// File: rtl/adc_spi_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_scheduler
// Brief    : Round-robin sharing of one ADC SPI engine among NREQ requesters.
//            Optional WAIT timeout enabled by defining ADC_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module adc_spi_scheduler #(
    parameter int NREQ        = 3,
    parameter int CH_W        = 3,
    parameter int DATA_W      = 12,
    parameter int TIMEOUT_CYC = 4096
) (
    input wire                 clk,
    input wire                 rst_n,
    adc_spi_scheduler_if.slave bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARB_GNT = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [CH_W-1:0]   spi_add_q, spi_add_d;
    logic              spi_start_w;
    logic              arb_found;
    logic [IDX_W-1:0]  arb_idx;
    int                arb_pos;

`ifdef ADC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsp_err_q, rsp_err_d;
`endif

    // Search starts one past the last winner so a just-served requester ranks last.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = ptr_q;
        arb_pos   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            arb_pos = (int'(ptr_q) + k) % NREQ;
            if (!arb_found && bus.req[arb_pos]) begin
                arb_found = 1'b1;
                arb_idx   = IDX_W'(arb_pos);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        spi_add_d   = spi_add_q;
        spi_start_w = 1'b0;
`ifdef ADC_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    win_d     = arb_idx;
                    ptr_d     = arb_idx;
                    gnt_d     = NREQ'(1) << arb_idx;
                    spi_add_d = bus.req_ch[int'(arb_idx)*CH_W +: CH_W];
                    state_d   = S_ARB_GNT;
                end
            end
            S_ARB_GNT: state_d = S_START;
            S_START: begin
                if (!bus.spi_busy) begin
                    spi_start_w = 1'b1;
                    state_d     = S_WAIT;
`ifdef ADC_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            S_WAIT: begin
                if (bus.spi_done) begin
                    rsp_valid_d = NREQ'(1) << win_q;
                    rsp_data_d  = bus.spi_data;
                    state_d     = S_RESP;
`ifdef ADC_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    rsp_valid_d = NREQ'(1) << win_q;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d       = cnt_q + CNT_W'(1);
`endif
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= IDX_W'(NREQ - 1);
            win_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            spi_add_q   <= '0;
`ifdef ADC_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            spi_add_q   <= spi_add_d;
`ifdef ADC_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.spi_add   = spi_add_q;
    assign bus.spi_start = spi_start_w;
`ifdef ADC_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_spi_scheduler
// Brief    : Directed self-checking bench for adc_spi_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_spi_scheduler;
    localparam int NREQ = 3;
    localparam int CH_W = 3;
    localparam int DATA_W = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   chs [3] = '{5, 3, 4};

    adc_spi_scheduler_if #(.NREQ(NREQ), .CH_W(CH_W), .DATA_W(DATA_W)) ifc ();

    adc_spi_scheduler #(
        .NREQ(NREQ), .CH_W(CH_W), .DATA_W(DATA_W), .TIMEOUT_CYC(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int idx);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (ifc.gnt == '0 && n < 20);
        chk("gnt", 32'(ifc.gnt), 32'(3'b001 << idx));
        chk("gnt_no_rsp", 32'(ifc.rsp_valid), 0);
        chk("spi_add_at_gnt", 32'(ifc.spi_add), 32'(chs[idx]));
    endtask

    // One full conversion; caller sets req beforehand, DUT must be idle.
    task automatic do_txn(input int idx, input logic [11:0] data, input int busy_cyc,
                          input bit early_done, input logic [2:0] req_after_gnt,
                          input logic [2:0] req_at_done);
        logic [8:0] saved_ch;
        wait_gnt(idx);
        ifc.req = req_after_gnt;
        saved_ch = ifc.req_ch;
        ifc.req_ch = ~ifc.req_ch;
        if (busy_cyc > 0) ifc.spi_busy = 1'b1;
        step();
        chk("gnt_one_cycle", 32'(ifc.gnt), 0);
        for (int i = 0; i < busy_cyc; i++) begin
            chk("start_held_busy", 32'(ifc.spi_start), 0);
            step();
        end
        ifc.spi_busy = 1'b0;
        if (early_done) begin
            ifc.spi_done = 1'b1;
            ifc.spi_data = 12'hFFF;
        end
        #1;
        chk("start_pulse", 32'(ifc.spi_start), 1);
        step();
        ifc.spi_done = 1'b0;
        ifc.spi_data = '0;
        for (int i = 0; i < 3; i++) begin
            chk("wait_quiet", 32'({ifc.spi_start, ifc.rsp_valid}), 0);
            step();
        end
        ifc.req = req_at_done;
        ifc.spi_done = 1'b1;
        ifc.spi_data = data;
        step();
        ifc.spi_done = 1'b0;
        ifc.spi_data = '0;
        chk("rsp_valid", 32'(ifc.rsp_valid), 32'(3'b001 << idx));
        chk("rsp_data", 32'(ifc.rsp_data), 32'(data));
        chk("rsp_err", 32'(ifc.rsp_err), 0);
        chk("rsp_no_gnt", 32'(ifc.gnt), 0);
        chk("spi_add_held", 32'(ifc.spi_add), 32'(chs[idx]));
        step();
        chk("rsp_one_cycle", 32'(ifc.rsp_valid), 0);
        chk("rsp_data_held", 32'(ifc.rsp_data), 32'(data));
        ifc.req_ch = saved_ch;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk(tag, 32'({ifc.gnt, ifc.rsp_valid, ifc.spi_start, ifc.rsp_err}), 0);
        chk({tag, "_data"}, 32'(ifc.rsp_data), 0);
        chk({tag, "_add"}, 32'(ifc.spi_add), 0);
    endtask

    initial begin
        int hits;
        int c;
        ifc.req = '0;
        ifc.req_ch = {3'd4, 3'd3, 3'd5};
        ifc.spi_busy = 1'b0;
        ifc.spi_done = 1'b0;
        ifc.spi_data = '0;
        repeat (3) step();
        chk_idle_outputs("reset");
        rst_n = 1'b1;

        // Single request on requester 0, channel 5
        ifc.req = 3'b001;
        do_txn(0, 12'hAC5, 0, 1'b0, 3'b000, 3'b000);
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (ifc.gnt != '0) hits++;
        end
        chk("no_req_no_gnt", 32'(hits), 0);

        // Reset restores first priority to requester 0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ifc.req = 3'b111;
        for (int k = 0; k < 6; k++)
            do_txn(k % 3, 12'(12'h100 + k * 17), 0, 1'b0, 3'b111, 3'b111);

        // Fairness: 1 served, then 0 and 2 pending -> 2 before 0
        ifc.req = 3'b010;
        do_txn(1, 12'h321, 0, 1'b0, 3'b101, 3'b101);
        do_txn(2, 12'h654, 10, 1'b0, 3'b001, 3'b001);
        do_txn(0, 12'h987, 0, 1'b1, 3'b000, 3'b000);

        // Requester 0 raises then drops req before it could be granted
        ifc.req = 3'b010;
        do_txn(1, 12'h0F0, 0, 1'b0, 3'b001, 3'b000);
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ifc.gnt != '0) hits++;
        end
        chk("dropped_req_no_gnt", 32'(hits), 0);

        // Reset during WAIT, late spi_done ignored
        ifc.req = 3'b100;
        wait_gnt(2);
        ifc.req = 3'b000;
        step();
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("rst_mid_wait");
        step();
        rst_n = 1'b1;
        step();
        ifc.spi_done = 1'b1;
        ifc.spi_data = 12'hABC;
        step();
        ifc.spi_done = 1'b0;
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            if (ifc.rsp_valid != '0 || ifc.spi_start) hits++;
            step();
        end
        chk("late_done_ignored", 32'(hits), 0);
        chk("late_done_data", 32'(ifc.rsp_data), 0);
        ifc.req = 3'b010;
        do_txn(1, 12'h5A5, 0, 1'b0, 3'b000, 3'b000);

        // No spi_done at all
        ifc.req = 3'b001;
        wait_gnt(0);
        ifc.req = 3'b000;
        step();
        step();
        c = 0;
        hits = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (ifc.rsp_valid != '0 && c == 0) c = i;
            if (ifc.rsp_valid != '0) hits++;
            if (ifc.rsp_valid != '0) begin
                chk("timeout_valid", 32'(ifc.rsp_valid), 1);
                chk("timeout_err", 32'(ifc.rsp_err), 1);
                chk("timeout_data", 32'(ifc.rsp_data), 0);
            end
        end
`ifdef ADC_TIMEOUT_EN
        chk("timeout_latency", 32'(c), 16);
        chk("timeout_pulses", 32'(hits), 1);
`else
        chk("no_timeout_rsp", 32'(hits), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
